// File: rtl/eda_neighbor_scan_ctrl_if.sv
// Pixel-memory read port for the neighbour scanner.
// Ready/valid request; read data returns exactly one cycle after acceptance.
interface eda_neighbor_scan_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output rd_valid, output rd_addr, input rd_ready, input rd_data);
    modport slave  (input rd_valid, input rd_addr, output rd_ready, output rd_data);
endinterface

// File: rtl/eda_neighbor_scan_ctrl.sv
// Neighbour-scan sequencer feeding the regional-maxima strobe RAM.
// Build option EDA_SCAN_CONN4_EN selects 4-connectivity (diagonal slots never fetched).
//
// state   | meaning
// IDLE    | waiting for start
// DECODE  | encode strobe, latch centre and neighbour table
// FETCH   | read centre, then in-bounds neighbours; fold the comparison
// EVAL    | present max result
// ADVANCE | step strobe to raster successor, or finish on last pixel
// DONE    | end-of-scan pulse

`ifndef CFG_M
`define CFG_M 8
`endif
`ifndef CFG_N
`define CFG_N 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 3
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 3
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 6
`endif

module eda_neighbor_scan_ctrl #(
    parameter int M          = `CFG_M,
    parameter int N          = `CFG_N,
    parameter int I_WIDTH    = `CFG_I_WIDTH,
    parameter int J_WIDTH    = `CFG_J_WIDTH,
    parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [M*N-1:0]          strb_value,
    eda_neighbor_scan_ctrl_if.master rd,
    output logic [ADDR_WIDTH-1:0]   pre_center_addr,
    output logic [8*ADDR_WIDTH-1:0] nb_addr,
    output logic [7:0]              nb_valid,
    output logic                    new_pixel,
    output logic                    update_strb,
    output logic [M-1:0]            sel_row,
    output logic [M*N-1:0]          sel_col,
    output logic                    max_valid,
    output logic                    is_max,
    output logic                    busy,
    output logic                    done
);

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);
`ifdef EDA_SCAN_CONN4_EN
    localparam logic [7:0] SLOT_EN = 8'b0101_1010;
`else
    localparam logic [7:0] SLOT_EN = 8'b1111_1111;
`endif

    typedef enum logic [2:0] {IDLE, DECODE, FETCH, EVAL, ADVANCE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [I_WIDTH-1:0]         ci_q, ci_d;
    logic [J_WIDTH-1:0]         cj_q, cj_d;
    logic [7:0][ADDR_WIDTH-1:0] nb_addr_q, nb_addr_d;
    logic [7:0]                 nb_valid_q, nb_valid_d;
    logic                       ctr_pend_q, ctr_pend_d;
    logic [7:0]                 slot_pend_q, slot_pend_d;
    logic                       rsp_pend_q, rsp_pend_d;
    logic                       rsp_ctr_q, rsp_ctr_d;
    logic [DATA_WIDTH-1:0]      ctr_data_q, ctr_data_d;
    logic                       acc_q, acc_d;
    logic                       is_max_q, is_max_d;

    logic                       enc_found;
    logic [I_WIDTH-1:0]         enc_i;
    logic [J_WIDTH-1:0]         enc_j;

    // Scanning downward so the last hit, i.e. the lowest set index, wins.
    always_comb begin
        enc_found = 1'b0;
        enc_i     = '0;
        enc_j     = '0;
        for (int i = M - 1; i >= 0; i--) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (strb_value[i*N + j]) begin
                    enc_found = 1'b1;
                    enc_i     = I_WIDTH'(i);
                    enc_j     = J_WIDTH'(j);
                end
            end
        end
    end

    logic [I_WIDTH-1:0]         im, ip;
    logic [J_WIDTH-1:0]         jm, jp;
    logic                       up_ok, dn_ok, lf_ok, rt_ok;
    logic [7:0][ADDR_WIDTH-1:0] cand_addr, tbl_addr;
    logic [7:0]                 tbl_valid;

    always_comb begin
        im    = enc_i - I_WIDTH'(1);
        ip    = enc_i + I_WIDTH'(1);
        jm    = enc_j - J_WIDTH'(1);
        jp    = enc_j + J_WIDTH'(1);
        up_ok = (enc_i != '0);
        dn_ok = (enc_i != I_LAST);
        lf_ok = (enc_j != '0);
        rt_ok = (enc_j != J_LAST);
        cand_addr[7] = {im, jm};
        cand_addr[6] = {im, enc_j};
        cand_addr[5] = {im, jp};
        cand_addr[4] = {enc_i, jm};
        cand_addr[3] = {enc_i, jp};
        cand_addr[2] = {ip, jm};
        cand_addr[1] = {ip, enc_j};
        cand_addr[0] = {ip, jp};
        tbl_valid = SLOT_EN & {up_ok & lf_ok, up_ok, up_ok & rt_ok, lf_ok, rt_ok,
                               dn_ok & lf_ok, dn_ok, dn_ok & rt_ok};
        for (int k = 0; k < 8; k++) begin
            tbl_addr[k] = tbl_valid[k] ? cand_addr[k] : {enc_i, enc_j};
        end
    end

    // Highest pending slot is issued next, giving the 7..0 order.
    logic [2:0] slot_sel;
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < 8; k++) begin
            if (slot_pend_q[k]) slot_sel = 3'(k);
        end
    end

    logic               issuing, accept, wrap, last_px;
    logic [I_WIDTH-1:0] nxt_i;
    logic [J_WIDTH-1:0] nxt_j;

    always_comb begin
        state_d     = state_q;
        ci_d        = ci_q;
        cj_d        = cj_q;
        nb_addr_d   = nb_addr_q;
        nb_valid_d  = nb_valid_q;
        ctr_pend_d  = ctr_pend_q;
        slot_pend_d = slot_pend_q;
        rsp_pend_d  = 1'b0;
        rsp_ctr_d   = rsp_ctr_q;
        ctr_data_d  = ctr_data_q;
        acc_d       = acc_q;
        is_max_d    = is_max_q;
        rd.rd_valid = 1'b0;
        rd.rd_addr  = '0;
        new_pixel   = 1'b0;
        update_strb = 1'b0;
        sel_row     = '0;
        sel_col     = '0;
        max_valid   = 1'b0;
        done        = 1'b0;
        issuing     = ctr_pend_q | (|slot_pend_q);
        accept      = 1'b0;
        wrap        = (cj_q == J_LAST);
        last_px     = wrap && (ci_q == I_LAST);
        nxt_i       = wrap ? ci_q + I_WIDTH'(1) : ci_q;
        nxt_j       = wrap ? '0 : cj_q + J_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start) state_d = DECODE;
            end
            DECODE: begin
                if (!enc_found) begin
                    state_d = DONE;
                end else begin
                    ci_d        = enc_i;
                    cj_d        = enc_j;
                    nb_addr_d   = tbl_addr;
                    nb_valid_d  = tbl_valid;
                    ctr_pend_d  = 1'b1;
                    slot_pend_d = tbl_valid;
                    acc_d       = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                rd.rd_valid = issuing;
                if (issuing) rd.rd_addr = ctr_pend_q ? {ci_q, cj_q} : nb_addr_q[slot_sel];
                accept     = issuing & rd.rd_ready;
                rsp_pend_d = accept;
                if (accept) begin
                    rsp_ctr_d = ctr_pend_q;
                    if (ctr_pend_q) ctr_pend_d = 1'b0;
                    else            slot_pend_d[slot_sel] = 1'b0;
                end
                if (rsp_pend_q) begin
                    if (rsp_ctr_q)                    ctr_data_d = rd.rd_data;
                    else if (rd.rd_data > ctr_data_q) acc_d      = 1'b0;
                    if (!issuing) state_d = EVAL;
                end
            end
            EVAL: begin
                max_valid = 1'b1;
                is_max_d  = acc_q;
                state_d   = ADVANCE;
            end
            ADVANCE: begin
                if (last_px) begin
                    state_d = DONE;
                end else begin
                    new_pixel   = 1'b1;
                    update_strb = 1'b1;
                    for (int i = 0; i < M; i++) begin
                        sel_row[i] = (nxt_i == I_WIDTH'(i));
                        for (int j = 0; j < N; j++) begin
                            sel_col[i*N + j] = (nxt_i == I_WIDTH'(i)) && (nxt_j == J_WIDTH'(j));
                        end
                    end
                    state_d = DECODE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ci_q        <= '0;
            cj_q        <= '0;
            nb_addr_q   <= '0;
            nb_valid_q  <= '0;
            ctr_pend_q  <= 1'b0;
            slot_pend_q <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_ctr_q   <= 1'b0;
            ctr_data_q  <= '0;
            acc_q       <= 1'b0;
            is_max_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ci_q        <= ci_d;
            cj_q        <= cj_d;
            nb_addr_q   <= nb_addr_d;
            nb_valid_q  <= nb_valid_d;
            ctr_pend_q  <= ctr_pend_d;
            slot_pend_q <= slot_pend_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_ctr_q   <= rsp_ctr_d;
            ctr_data_q  <= ctr_data_d;
            acc_q       <= acc_d;
            is_max_q    <= is_max_d;
        end
    end

    assign pre_center_addr = {ci_q, cj_q};
    assign nb_addr         = nb_addr_q;
    assign nb_valid        = nb_valid_q;
    assign is_max          = (state_q == EVAL) ? acc_q : is_max_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_eda_neighbor_scan_ctrl.sv
// Randomised bench for eda_neighbor_scan_ctrl on a 4x4 image, checked against a
// geometric reference model of neighbour order, max decision, raster step and timing.
module tb_eda_neighbor_scan_ctrl;
    localparam int M = 4, N = 4, IW = 2, JW = 2, AW = 4, DW = 8, P = M * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [P-1:0]  strb_value;
    logic [AW-1:0] pre_center_addr;
    logic [8*AW-1:0] nb_addr;
    logic [7:0]    nb_valid;
    logic          new_pixel, update_strb;
    logic [M-1:0]  sel_row;
    logic [P-1:0]  sel_col;
    logic          max_valid, is_max, busy, done;

    eda_neighbor_scan_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();

    eda_neighbor_scan_ctrl #(
        .M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .strb_value(strb_value), .rd(rd_if),
        .pre_center_addr(pre_center_addr), .nb_addr(nb_addr), .nb_valid(nb_valid),
        .new_pixel(new_pixel), .update_strb(update_strb), .sel_row(sel_row), .sel_col(sel_col),
        .max_valid(max_valid), .is_max(is_max), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]    mem [P];
    bit            pend, prev_stall;
    int            pend_addr;
    logic [AW-1:0] prev_addr;
    int            obs_q[$], exp_q[$];
    logic [7:0]    exp_nbv;
    logic [8*AW-1:0] exp_nba;
    bit            exp_max;
    // Row/column offset of each neighbour slot, indexed by slot number.
    int DI [8] = '{1, 1, 1, 0, 0, -1, -1, -1};
    int DJ [8] = '{1, 0, -1, 1, -1, 1, 0, -1};

    function automatic void model_pixel(input int idx);
        int ci, cj, ni, nj;
        bit ok;
        ci = idx / N;
        cj = idx % N;
        exp_q.delete();
        exp_q.push_back(idx);
        exp_nbv = '0;
        exp_nba = '0;
        exp_max = 1'b1;
        for (int s = 7; s >= 0; s--) begin
            ni = ci + DI[s];
            nj = cj + DJ[s];
            ok = (ni >= 0) && (ni < M) && (nj >= 0) && (nj < N);
`ifdef EDA_SCAN_CONN4_EN
            if (DI[s] != 0 && DJ[s] != 0) ok = 1'b0;
`endif
            exp_nba[s*AW +: AW] = ok ? AW'(ni * N + nj) : AW'(idx);
            if (ok) begin
                exp_nbv[s] = 1'b1;
                exp_q.push_back(ni * N + nj);
                if (mem[ni * N + nj] > mem[idx]) exp_max = 1'b0;
            end
        end
    endfunction

    // One clock: drive inputs at the falling edge, act as the pixel memory.
    task automatic bus_cycle(input bit rdy, input bit st);
        @(negedge clk);
        start = st;
        rd_if.rd_data = pend ? mem[pend_addr] : 8'($urandom);
        if (prev_stall) check_eq("addr_hold", {rd_if.rd_valid, rd_if.rd_addr}, {1'b1, prev_addr});
        rd_if.rd_ready = rdy;
        prev_stall = rd_if.rd_valid && !rdy;
        prev_addr  = rd_if.rd_addr;
        pend = rd_if.rd_valid && rdy;
        if (pend) begin
            pend_addr = int'(rd_if.rd_addr);
            obs_q.push_back(int'(rd_if.rd_addr));
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        start = 1'b0;
        rd_if.rd_ready = 1'b0;
        pend = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for three FETCH cycles
    task automatic run_scan(input logic [P-1:0] strb0, input int mode);
        int idx, cyc, nmax;
        bit fin, got_max, seen_np, seen_done, last, rdy;
        idx = -1;
        for (int k = P - 1; k >= 0; k--) if (strb0[k]) idx = k;
        strb_value = strb0;
        bus_cycle(1'b1, 1'b1);
        check_eq("idle_busy", busy, 0);
        if (idx < 0) begin
            bus_cycle(1'b1, 1'b0);
            bus_cycle(1'b1, 1'b0);
            check_eq("zero_strb_done", done, 1);
            check_eq("zero_strb_max", max_valid, 0);
            bus_cycle(1'b1, 1'b0);
            check_eq("zero_strb_busy", busy, 0);
            return;
        end
        fin = 1'b0;
        while (!fin) begin
            model_pixel(idx);
            last = (idx == P - 1);
            obs_q.delete();
            cyc = 0; nmax = 0; got_max = 1'b0; seen_np = 1'b0; seen_done = 1'b0;
            while (cyc < 100 && !seen_np && !seen_done) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = !(cyc >= 3 && cyc < 6);
                endcase
                bus_cycle(rdy, 1'($urandom_range(0, 1)));
                cyc++;
                if (cyc == 2) begin
                    check_eq("nb_valid", nb_valid, exp_nbv);
                    check_eq("nb_addr", nb_addr, exp_nba);
                    check_eq("pre_center_addr", pre_center_addr, idx);
                    check_eq("fetch_busy", busy, 1);
                    check_eq("fetch_no_sel", {new_pixel, update_strb, sel_row, sel_col}, 0);
                end
                if (max_valid) begin
                    nmax++;
                    got_max = is_max;
                end
                if (new_pixel) begin
                    seen_np = 1'b1;
                    check_eq("update_strb", update_strb, 1);
                    check_eq("sel_row", sel_row, 64'(1) << ((idx + 1) / N));
                    check_eq("sel_col", sel_col, 64'(1) << (idx + 1));
                    check_eq("is_max_hold", is_max, exp_max);
                    strb_value = P'(1) << (idx + 1);
                end
                if (done) seen_done = 1'b1;
            end
            if (!seen_np && !seen_done) begin
                check_eq("pixel_timeout_cycles", cyc, exp_q.size() + 4);
                reset_dut();
                return;
            end
            check_eq("end_is_done", seen_done, last);
            check_eq("end_is_new_pixel", seen_np, !last);
            check_eq("max_pulses", nmax, 1);
            check_eq("is_max", got_max, exp_max);
            check_eq("n_reads", obs_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
                check_eq($sformatf("rd_addr[%0d] px%0d", k, idx), obs_q[k], exp_q[k]);
            if (mode == 0) check_eq("pixel_cycles", cyc, exp_q.size() + (last ? 5 : 4));
            if (last) begin
                bus_cycle(1'b1, 1'b0);
                check_eq("busy_after_done", busy, 0);
                check_eq("done_one_cycle", done, 0);
                check_eq("is_max_held", is_max, exp_max);
                fin = 1'b1;
            end else begin
                idx++;
            end
        end
    endtask

    function automatic void fill_random(input int maxv);
        for (int a = 0; a < P; a++) mem[a] = 8'($urandom_range(0, maxv));
    endfunction

    function automatic void set_case1();
        fill_random(15);
        mem[0] = 9; mem[1] = 3; mem[4] = 3; mem[5] = 3;
    endfunction

    function automatic void set_case2();
        fill_random(15);
        mem[5] = 10; mem[10] = 12;
        mem[0] = 4; mem[1] = 4; mem[2] = 4; mem[4] = 4; mem[6] = 4; mem[8] = 4; mem[9] = 4;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        strb_value = '0;
        rd_if.rd_data = '0;
        fill_random(7);
        reset = 1'b1;
        start = 1'b0;
        rd_if.rd_ready = 1'b0;
        pend = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd", {rd_if.rd_valid, rd_if.rd_addr}, 0);
        check_eq("rst_nb", {nb_valid, nb_addr, pre_center_addr}, 0);
        check_eq("rst_sel", {new_pixel, update_strb, sel_row, sel_col}, 0);
        check_eq("rst_result", {max_valid, is_max, done}, 0);
        reset = 1'b0;

        set_case1();
        run_scan(P'(1), 0);
        set_case2();
        run_scan(P'(1) << 5, 0);
        fill_random(15);
        mem[7] = 7; mem[2] = 7; mem[3] = 7; mem[6] = 7; mem[10] = 7; mem[11] = 7;
        run_scan(P'(1) << 7, 0);
        set_case2();
        run_scan(P'(1) << 5, 2);

        // Reset in the middle of a FETCH with a read response outstanding.
        set_case2();
        strb_value = P'(1) << 5;
        bus_cycle(1'b1, 1'b1);
        repeat (4) bus_cycle(1'b1, 1'b0);
        check_eq("pre_rst_rd_valid", rd_if.rd_valid, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_rd_valid", rd_if.rd_valid, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_new_pixel", new_pixel, 0);
        pend = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        set_case1();
        run_scan(P'(1), 0);

        run_scan('0, 0);
        fill_random(7);
        run_scan((P'(1) << 6) | (P'(1) << 9) | (P'(1) << 15), 1);
        for (int r = 0; r < 4; r++) begin
            fill_random(7);
            run_scan(P'(1) << $urandom_range(0, P - 1), r % 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
